// File: rtl/sys_irq_ctrl_pkg.sv
// Shared constants for the SYSTEM interrupt aggregator: register map,
// ACTIVE register field positions and source-id width.
package sys_irq_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int ID_W = 4;
  localparam int ACTIVE_VALID_BIT = 15;

  localparam logic [ADDR_W-1:0] ADDR_PENDING = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_MODE = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_ACTIVE = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_RAW = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_CONTROL = 3'd5;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: reports whether any bit is set and the
// index of the lowest set bit (0 when none).
module irq_prio_enc
  import sys_irq_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]    vec,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    valid = 1'b0;
    id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid = 1'b1;
        id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/sys_irq_ctrl.sv
// Interrupt aggregator: synchronizes request lines, latches them as level or
// rising-edge events, masks them and drives a single registered CPU irq.
module sys_irq_ctrl
  import sys_irq_ctrl_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [DATA_W-1:0]  writedata,
  output logic [DATA_W-1:0]  readdata,
  input  logic [N_IRQ-1:0]   irq_in,
  output logic               irq
);

  logic [N_IRQ-1:0] s;
  logic [N_IRQ-1:0] s_d;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] pending_next;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] edge_mode;
  logic [N_IRQ-1:0] w1c;
  logic             enable;
  logic             wr;
  logic             wr_pending;
  logic             wr_mask;
  logic             wr_edge_mode;
  logic             wr_control;
  logic             active_valid;
  logic [ID_W-1:0]  active_id;
  logic [DATA_W-1:0] rd_mux;
  logic             unused_wdata;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = irq_in;
    end else begin : g_sync
      logic [N_IRQ-1:0] chain [SYNC_STAGES];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < SYNC_STAGES; k++) chain[k] <= '0;
        end else begin
          chain[0] <= irq_in;
          for (int k = 1; k < SYNC_STAGES; k++) chain[k] <= chain[k-1];
        end
      end
      assign s = chain[SYNC_STAGES-1];
    end
  endgenerate

  assign rise = s & ~s_d;

  assign wr = chipselect & ~write_n;
  assign wr_pending = wr && (address == ADDR_PENDING);
  assign wr_mask = wr && (address == ADDR_MASK);
  assign wr_edge_mode = wr && (address == ADDR_EDGE_MODE);
  assign wr_control = wr && (address == ADDR_CONTROL);

  assign unused_wdata = &{1'b0, writedata[DATA_W-1:N_IRQ]};

  // A rise on the same edge as its W1C keeps the bit set so no event is lost;
  // level sources simply track the synchronized line.
  always_comb begin
    w1c = wr_pending ? writedata[N_IRQ-1:0] : '0;
    pending_next = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (edge_mode[i]) pending_next[i] = rise[i] | (pending[i] & ~w1c[i]);
      else pending_next[i] = s[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_d <= '0;
      pending <= '0;
      mask <= '0;
      edge_mode <= '0;
      enable <= 1'b0;
    end else begin
      s_d <= s;
      pending <= pending_next;
      if (wr_mask) mask <= writedata[N_IRQ-1:0];
      if (wr_edge_mode) edge_mode <= writedata[N_IRQ-1:0];
      if (wr_control) enable <= writedata[0];
    end
  end

  irq_prio_enc #(
    .N(N_IRQ)
  ) u_prio_enc (
    .vec  (pending & mask),
    .valid(active_valid),
    .id   (active_id)
  );

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_PENDING:   rd_mux[N_IRQ-1:0] = pending;
      ADDR_MASK:      rd_mux[N_IRQ-1:0] = mask;
      ADDR_EDGE_MODE: rd_mux[N_IRQ-1:0] = edge_mode;
      ADDR_ACTIVE: begin
        rd_mux[ACTIVE_VALID_BIT] = active_valid;
        rd_mux[ID_W-1:0] = active_id;
      end
      ADDR_RAW:       rd_mux[N_IRQ-1:0] = s;
      ADDR_CONTROL:   rd_mux[0] = enable;
      default:        rd_mux = '0;
    endcase
  end

  // Read data is refreshed every clock regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq <= enable & (|(pending & mask));
    end
  end

endmodule

// File: tb/tb_sys_irq_ctrl.sv
// Directed bench for sys_irq_ctrl: register access, edge/level latching,
// W1C races, priority reporting, global enable and asynchronous reset.
module tb_sys_irq_ctrl;

  localparam int N_IRQ = 8;
  localparam int SYNC_STAGES = 2;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [N_IRQ-1:0] irq_in;
  logic        irq;

  int n_checks;
  int n_fail;

  sys_irq_ctrl #(
    .N_IRQ(N_IRQ),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq_in    (irq_in),
    .irq       (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change on the falling edge, outputs sampled there too
  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a;
    chipselect = 1'b1;
    write_n = 1'b0;
    writedata = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    address = a;
    chipselect = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wait_clocks(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] d;
    reset_n = 1'b0;
    #12;
    n_checks++;
    if (readdata !== 16'h0000 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: readdata=%h irq=%b, required 0000/0", readdata, irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d);
      n_checks++;
      if (d !== 16'h0000 || irq !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: data=%h irq=%b, required 0000/0", a, d, irq);
      end
    end
  endtask

  task automatic test_edge_pulse();
    logic [15:0] d;
    bus_write(3'd1, 16'h0001);
    bus_write(3'd5, 16'h0001);
    bus_write(3'd2, 16'h0001);
    @(negedge clk);
    irq_in[0] = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 2; k++) begin
      @(negedge clk);
      irq_in[0] = 1'b0;
      if (k >= SYNC_STAGES + 1) begin
        n_checks++;
        if (irq !== (k == SYNC_STAGES + 2)) begin
          n_fail++;
          $display("FAIL edge_latency_k%0d: irq=%b, required %b", k, irq, k == SYNC_STAGES + 2);
        end
      end
    end
    bus_read(3'd0, d);
    n_checks++;
    if (d !== 16'h0001) begin
      n_fail++;
      $display("FAIL edge_pending: got %h, required 0001", d);
    end
    bus_write(3'd0, 16'h0001);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_w1c_same_clk: irq=%b, required 1", irq);
    end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_w1c_next_clk: irq=%b, required 0", irq);
    end
  endtask

  task automatic test_level();
    logic [15:0] d;
    bus_write(3'd2, 16'h0000);
    bus_write(3'd1, 16'h0004);
    @(negedge clk);
    irq_in[2] = 1'b1;
    wait_clocks(6);
    bus_read(3'd4, d);
    n_checks++;
    if (d !== 16'h0004) begin
      n_fail++;
      $display("FAIL level_raw: got %h, required 0004", d);
    end
    bus_write(3'd0, 16'h0004);
    bus_read(3'd0, d);
    n_checks++;
    if (d !== 16'h0004 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL level_w1c_held: pending=%h irq=%b, required 0004/1", d, irq);
    end
    @(negedge clk);
    irq_in[2] = 1'b0;
    for (int k = 1; k <= SYNC_STAGES + 2; k++) begin
      @(negedge clk);
      if (k >= SYNC_STAGES + 1) begin
        n_checks++;
        if (irq !== (k != SYNC_STAGES + 2)) begin
          n_fail++;
          $display("FAIL level_drop_k%0d: irq=%b, required %b", k, irq, k != SYNC_STAGES + 2);
        end
      end
    end
    bus_read(3'd0, d);
    n_checks++;
    if (d !== 16'h0000) begin
      n_fail++;
      $display("FAIL level_pending_drop: got %h, required 0000", d);
    end
  endtask

  task automatic test_w1c_race();
    logic [15:0] d;
    bus_write(3'd2, 16'h0008);
    bus_write(3'd1, 16'h0008);
    @(negedge clk);
    irq_in[3] = 1'b1;
    @(negedge clk);
    irq_in[3] = 1'b0;
    wait_clocks(5);
    bus_write(3'd0, 16'h0008);
    bus_read(3'd0, d);
    n_checks++;
    if (d !== 16'h0000) begin
      n_fail++;
      $display("FAIL race_plain_clear: got %h, required 0000", d);
    end
    // rise reaches the edge detector on the third edge after the input change
    @(negedge clk);
    irq_in[3] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    address = 3'd0;
    chipselect = 1'b1;
    write_n = 1'b0;
    writedata = 16'h0008;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = '0;
    bus_read(3'd0, d);
    n_checks++;
    if (d !== 16'h0008) begin
      n_fail++;
      $display("FAIL race_set_wins: got %h, required 0008", d);
    end
    irq_in[3] = 1'b0;
    wait_clocks(4);
  endtask

  task automatic test_priority();
    logic [15:0] d;
    bus_write(3'd2, 16'h000A);
    bus_write(3'd0, 16'h00FF);
    @(negedge clk);
    irq_in = 8'h0A;
    @(negedge clk);
    irq_in = 8'h00;
    wait_clocks(5);
    bus_write(3'd1, 16'h000A);
    bus_read(3'd3, d);
    n_checks++;
    if (d !== 16'h8001) begin
      n_fail++;
      $display("FAIL active_0a: got %h, required 8001", d);
    end
    bus_write(3'd1, 16'h0008);
    bus_read(3'd3, d);
    n_checks++;
    if (d !== 16'h8003) begin
      n_fail++;
      $display("FAIL active_08: got %h, required 8003", d);
    end
    bus_write(3'd1, 16'h0000);
    bus_read(3'd3, d);
    n_checks++;
    if (d !== 16'h0000 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL active_none: active=%h irq=%b, required 0000/0", d, irq);
    end
    bus_read(3'd0, d);
    n_checks++;
    if (d !== 16'h000A) begin
      n_fail++;
      $display("FAIL mask_keeps_pending: got %h, required 000a", d);
    end
  endtask

  task automatic test_enable_and_reset();
    logic [15:0] d;
    bus_write(3'd1, 16'h000A);
    bus_write(3'd5, 16'h0000);
    wait_clocks(2);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_off: irq=%b, required 0", irq);
    end
    bus_write(3'd5, 16'h0001);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_same_clk: irq=%b, required 0", irq);
    end
    @(negedge clk);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_on: irq=%b, required 1", irq);
    end
    address = 3'd1;
    @(negedge clk);
    n_checks++;
    if (readdata !== 16'h000A) begin
      n_fail++;
      $display("FAIL pre_reset_read: got %h, required 000a", readdata);
    end
    irq_in[0] = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (irq !== 1'b0 || readdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: irq=%b readdata=%h, required 0/0000", irq, readdata);
    end
    @(negedge clk);
    irq_in[0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_clocks(5);
    bus_read(3'd1, d);
    n_checks++;
    if (d !== 16'h0000) begin
      n_fail++;
      $display("FAIL post_reset_mask: got %h, required 0000", d);
    end
    bus_read(3'd0, d);
    n_checks++;
    if (d !== 16'h0000 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_pending: pending=%h irq=%b, required 0000/0", d, irq);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    address = '0;
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = '0;
    irq_in = '0;
    reset_n = 1'b0;
    test_reset();
    test_edge_pulse();
    test_level();
    test_w1c_race();
    test_priority();
    test_enable_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
